cl_burst_adaptor: RTL
=====================

CL_BURST_ADAPTOR -- requirements
Module: cl_burst_adaptor

Interface
REQ-001 The block SHALL have parameter s_line, default 256, cache line width in bits.
REQ-002 The block SHALL have parameter s_burst, default 64, memory beat width in bits; beats = s_line/s_burst = 4.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-low
line_i  in  s_line  line to write back (cache side)
line_o  out  s_line  line assembled from memory
address_i  in  32  line address from cache
read_i  in  1  line fill request
write_i  in  1  line writeback request
resp_o  out  1  one-cycle completion pulse
burst_i  in  s_burst  read beat from memory
burst_o  out  s_burst  write beat to memory
address_o  out  32  line-aligned memory address
read_o  out  1  memory read request
write_o  out  1  memory write request
resp_i  in  1  memory beat valid/accepted

Function
REQ-004 The FSM SHALL have states IDLE, READ, WRITE, DONE.
REQ-005 In IDLE, write_i=1 SHALL latch line_i and {address_i[31:5],5'b0} and go to WRITE; else read_i=1 SHALL latch the address and go to READ.
REQ-006 When read_i and write_i are both 1 in IDLE, write SHALL win; read_i is ignored.
REQ-007 read_i, write_i, address_i and line_i SHALL be ignored outside IDLE.
REQ-008 read_o SHALL be 1 exactly in READ; write_o exactly in WRITE; address_o SHALL hold the latched address while not IDLE.
REQ-009 A 2-bit beat counter SHALL be cleared on request acceptance and incremented on each edge with resp_i=1 in READ or WRITE.
REQ-010 In READ, each edge with resp_i=1 SHALL store burst_i into line_o[count*64 +: 64].
REQ-011 In WRITE, burst_o SHALL equal latched_line[count*64 +: 64] combinationally; outside WRITE, burst_o SHALL be 0.
REQ-012 The edge accepting beat 3 (count=3, resp_i=1) SHALL move the FSM to DONE; the counter wraps to 0.
REQ-013 resp_i=0 in READ/WRITE SHALL stall: no capture, counter holds, request stays asserted, no timeout.
REQ-014 In DONE, resp_o SHALL be 1 for exactly one cycle and read_o/write_o 0; the next state SHALL be IDLE unconditionally.
REQ-015 line_o SHALL hold its value from the last completed read until the next read beat is captured; it is valid when resp_o=1 after a read.
REQ-016 resp_i in IDLE or DONE SHALL be ignored.
REQ-017 Minimum latency SHALL be 6 cycles from request sample to resp_o: 1 accept + 4 beats + 1 DONE.

Reset
REQ-018 rst=0 SHALL, asynchronously, force IDLE and count=0, and clear resp_o, read_o, write_o, address_o, line_o, and the latched line.
REQ-019 Reset mid-transfer SHALL abort the transfer with no resp_o; the next request after release SHALL start at beat 0.

Configuration
REQ-020 With CL_BURST_PERF_EN defined, outputs rd_lines_o[31:0] and wr_lines_o[31:0] SHALL exist and increment (wrapping 0xFFFFFFFF->0) on each DONE cycle of a read or write; rst clears them.
REQ-021 Without CL_BURST_PERF_EN, those ports and counters SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-022 Read, address_i=0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive cycles -> address_o=0x0000_1220, line_o={0x44..44,0x33..33,0x22..22,0x11..11}, resp_o 1 cycle, latency 6.
REQ-023 Write, line_i=0xDDDD..CCCC..BBBB..AAAA (64-bit words, high to low) -> burst_o sequence 0xAAAA.., 0xBBBB.., 0xCCCC.., 0xDDDD..; write_o high until beat 3 is accepted.
REQ-024 Read with resp_i low for 3 cycles between beats 1 and 2 -> read_o stays high, count holds, final line is correct, latency 9.
REQ-025 read_i=write_i=1 in IDLE -> write transfer only; read_o never asserted.
REQ-026 rst=0 after beat 2 of a read -> read_o=0 immediately, no resp_o; a new read starts at beat 0 and completes correctly.
REQ-027 With CL_BURST_PERF_EN: 2 reads and 1 write -> rd_lines_o=2, wr_lines_o=1; preset to 0xFFFFFFFF, one more read -> rd_lines_o=0.

Source files
------------

// File: rtl/cl_burst_adaptor.sv
// Cache-line to memory-burst adaptor: splits a line writeback into beats and
// assembles a line fill from beats. Optional perf counters under CL_BURST_PERF_EN.
module cl_burst_adaptor #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
`ifdef CL_BURST_PERF_EN
  ,
  output logic [31:0]        rd_lines_o,
  output logic [31:0]        wr_lines_o
`endif
);

  localparam int beats = s_line / s_burst;
  localparam int cnt_w = (beats > 1) ? $clog2(beats) : 1;
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(beats - 1);
  // Byte offset bits inside a line are dropped so memory sees line-aligned addresses.
  localparam logic [31:0] align_mask = ~(32'(s_line / 8) - 32'd1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t             state_q, state_d;
  logic [cnt_w-1:0]   cnt_q;
  logic [31:0]        addr_q;
  logic [s_line-1:0]  line_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (write_i)     state_d = WRITE;
        else if (read_i) state_d = READ;
      end
      READ, WRITE: begin
        if (resp_i && cnt_q == last_beat) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign resp_o    = (state_q == DONE);
  assign address_o = addr_q;
  assign burst_o   = (state_q == WRITE) ? line_q[cnt_q*s_burst +: s_burst] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      line_o  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (write_i) begin
            line_q <= line_i;
            addr_q <= address_i & align_mask;
            cnt_q  <= '0;
          end else if (read_i) begin
            addr_q <= address_i & align_mask;
            cnt_q  <= '0;
          end
        end
        READ: begin
          if (resp_i) begin
            line_o[cnt_q*s_burst +: s_burst] <= burst_i;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WRITE: begin
          if (resp_i) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CL_BURST_PERF_EN
  logic        dir_rd_q;
  logic [31:0] rd_lines_q, wr_lines_q;

  // Direction is remembered at accept so DONE knows which counter to bump.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_rd_q   <= 1'b0;
      rd_lines_q <= '0;
      wr_lines_q <= '0;
    end else begin
      if (state_q == IDLE) begin
        if (write_i)     dir_rd_q <= 1'b0;
        else if (read_i) dir_rd_q <= 1'b1;
      end
      if (state_q == DONE) begin
        if (dir_rd_q) rd_lines_q <= rd_lines_q + 32'd1;
        else          wr_lines_q <= wr_lines_q + 32'd1;
      end
    end
  end

  assign rd_lines_o = rd_lines_q;
  assign wr_lines_o = wr_lines_q;
`endif

endmodule
